tt_phase_sequencer: RTL and testbench

Timed three-phase sequencer for a TinyTapeout user slot. It steps RED → GREEN → YELLOW → RED with per-phase dwell times counted in prescaled ticks, and drives lamp, phase-code and status bits on `io_out`. It supports a hold input and an optional pedestrian-request path that shortens GREEN and grants a WALK indication in the following RED. It replaces free-running two-flop phase rings with a controlled, programmable sequence behind the same 8-in/8-out pin frame.

---
 rtl/tt_phase_sequencer.sv | 158 +++++++++++++++
 tb/tb_tt_phase_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_phase_sequencer.sv
// Timed RED -> GREEN -> YELLOW sequencer in the 8-in/8-out TinyTapeout pin frame.
// Dwell times are counted in prescaled ticks of 2^(TICK_SHIFT+sel) clocks.
// Build option: define SEQ_PED_EN to add the pedestrian request path
// (req synchronizer, ped_pending, GREEN cut, WALK). Without it, req is ignored
// and io_out[4:3] are tied low.
//
// state     | meaning
// PH_RED    | red lamp, dwell RED_T ticks, WALK shown if granted on entry
// PH_GREEN  | green lamp, dwell GREEN_T ticks (cut to GREEN_MIN left on request)
// PH_YELLOW | yellow lamp, dwell YELLOW_T ticks
module tt_phase_sequencer #(
    parameter int TICK_SHIFT = 2,
    parameter int GREEN_T    = 8,
    parameter int YELLOW_T   = 2,
    parameter int RED_T      = 6,
    parameter int GREEN_MIN  = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        PH_RED    = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_t;

    logic       clk;
    logic       rst_n;
    logic       hold;
    logic [1:0] sel;

    assign clk   = io_in[0];
    assign rst_n = io_in[1];
    assign hold  = io_in[2];
    assign sel   = io_in[5:4];

    logic [11:0] prescale;
    logic [3:0]  shift_amt;
    logic [11:0] tick_mask;
    logic        tick;

    phase_t      phase, phase_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        advance;
    logic        ped_cut;
    logic        walk;
    logic        ped_pending;

    // sel is applied directly to the mask; no realignment on change
    assign shift_amt = 4'(TICK_SHIFT) + {2'b00, sel};
    assign tick_mask = ~(12'hFFF << shift_amt);
    assign tick      = (prescale & tick_mask) == tick_mask;
    assign advance   = tick && !hold && (cnt == 4'd0);

    // Free-running prescaler; keeps counting while hold is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prescale <= '0;
        else        prescale <= prescale + 12'd1;
    end

    // Phase and dwell counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_RED;
            cnt   <= 4'(RED_T - 1);
        end else begin
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next phase / dwell: advance on an unheld tick at cnt=0, else count down
    always_comb begin
        phase_nxt = phase;
        cnt_nxt   = cnt;
        if (advance) begin
            case (phase)
                PH_RED: begin
                    phase_nxt = PH_GREEN;
                    cnt_nxt   = 4'(GREEN_T - 1);
                end
                PH_GREEN: begin
                    phase_nxt = PH_YELLOW;
                    cnt_nxt   = 4'(YELLOW_T - 1);
                end
                default: begin
                    phase_nxt = PH_RED;
                    cnt_nxt   = 4'(RED_T - 1);
                end
            endcase
        end else if (tick && !hold) begin
            if (ped_cut) cnt_nxt = 4'(GREEN_MIN - 1);
            else         cnt_nxt = cnt - 4'd1;
        end
    end

`ifdef SEQ_PED_EN
    logic req_s1, req_s2, req_q;
    logic req_edge;
    logic walk_nxt, ped_nxt;
    logic unused_in;

    assign unused_in = ^io_in[7:6];
    assign req_edge  = req_s2 & ~req_q;
    assign ped_cut   = ped_pending && (phase == PH_GREEN) && (cnt > 4'(GREEN_MIN - 1));

    // Two-flop synchronizer plus a delay flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_s1 <= 1'b0;
            req_s2 <= 1'b0;
            req_q  <= 1'b0;
        end else begin
            req_s1 <= io_in[3];
            req_s2 <= req_s1;
            req_q  <= req_s2;
        end
    end

    // Pedestrian request and WALK registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walk        <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            walk        <= walk_nxt;
            ped_pending <= ped_nxt;
        end
    end

    // RED entry grants WALK and consumes the request; an edge in that same
    // cycle re-arms ped_pending for the following RED
    always_comb begin
        walk_nxt = walk;
        ped_nxt  = ped_pending;
        if (advance && (phase == PH_YELLOW)) begin
            walk_nxt = ped_pending;
            ped_nxt  = req_edge;
        end else begin
            if (advance && (phase == PH_RED)) walk_nxt = 1'b0;
            if (req_edge)                     ped_nxt  = 1'b1;
        end
    end
`else
    logic unused_in;

    assign unused_in   = ^{io_in[7:6], io_in[3]};
    assign ped_cut     = 1'b0;
    assign walk        = 1'b0;
    assign ped_pending = 1'b0;
`endif

    // Tick strobe is gated by reset so io_out reads 0x01 throughout reset
    assign io_out = {phase, tick & rst_n, ped_pending, walk,
                     phase == PH_GREEN, phase == PH_YELLOW, phase == PH_RED};

endmodule

// File: tb/tb_tt_phase_sequencer.sv
// Directed bench for tt_phase_sequencer with default parameters.
// Follows the SEQ_PED_EN build option of the design.
module tb_tt_phase_sequencer;

    localparam int LIMIT = 2000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold  = 1'b0;
    logic       req   = 1'b0;
    logic [1:0] sel   = 2'b00;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int errors = 0;
    int checks = 0;

    assign io_in = {2'b00, sel, req, hold, rst_n, clk};

    tt_phase_sequencer dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    // Wait one clock; inputs change and outputs are read 1 ns after the edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset(input logic [1:0] s);
        rst_n = 1'b0;
        hold  = 1'b0;
        req   = 1'b0;
        sel   = s;
        step(3);
        rst_n = 1'b1;
    endtask

    // Counts edges until the phase code leaves `code`; tallies cycles whose
    // non-tick bits differ from exp_val and, if toff >= 0, tick strobes that
    // do not fall on a P=4 grid (toff = edges already spent in this phase).
    task automatic measure(input logic [1:0] code, input logic [7:0] exp_val, input int toff,
                           output int len, output int bad_val, output int bad_tick);
        len = 0;
        bad_val = 0;
        bad_tick = 0;
        while (len < LIMIT) begin
            step(1);
            len++;
            if (io_out[7:6] !== code) break;
            if ((io_out & 8'hDF) !== exp_val) bad_val++;
            if (toff >= 0 && (io_out[5] !== (((len + toff) % 4) == 3))) bad_tick++;
        end
    endtask

    task automatic test_reset();
        int len, bv, bt;
        checks++;
        if (io_out !== 8'h01) begin
            errors++;
            $display("FAIL reset_hold: io_out=%h expected 01", io_out);
        end
        apply_reset(2'b00);
        measure(2'b00, 8'h01, 0, len, bv, bt);
        checks++;
        if (len !== 24) begin
            errors++;
            $display("FAIL reset_first_red_len: got %0d expected 24", len);
        end
        checks++;
        if ((io_out & 8'hDF) !== 8'h44) begin
            errors++;
            $display("FAIL reset_green_entry: io_out=%h expected 44", io_out);
        end
        step(10);
        rst_n = 1'b0;
        #1;
        checks++;
        if (io_out !== 8'h01) begin
            errors++;
            $display("FAIL reset_async_mid_green: io_out=%h expected 01", io_out);
        end
        step(2);
        checks++;
        if (io_out !== 8'h01) begin
            errors++;
            $display("FAIL reset_held: io_out=%h expected 01", io_out);
        end
        rst_n = 1'b1;
        measure(2'b00, 8'h01, 0, len, bv, bt);
        checks++;
        if (len !== 24 || bv !== 0 || bt !== 0) begin
            errors++;
            $display("FAIL reset_rerun_red: len=%0d badval=%0d badtick=%0d expected 24/0/0", len, bv, bt);
        end
        checks++;
        if ((io_out & 8'hDF) !== 8'h44) begin
            errors++;
            $display("FAIL reset_rerun_green: io_out=%h expected 44", io_out);
        end
    endtask

    task automatic test_free_run();
        int len, bv, bt;
        logic [1:0]  codes [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic [7:0]  vals  [4] = '{8'h01, 8'h44, 8'h82, 8'h01};
        int          lens  [4] = '{24, 32, 8, 24};
        apply_reset(2'b00);
        for (int i = 0; i < 4; i++) begin
            measure(codes[i], vals[i], 0, len, bv, bt);
            checks++;
            if (len !== lens[i]) begin
                errors++;
                $display("FAIL free_run_len[%0d]: got %0d expected %0d", i, len, lens[i]);
            end
            checks++;
            if (bv !== 0) begin
                errors++;
                $display("FAIL free_run_value[%0d]: %0d cycles differ from %h", i, bv, vals[i]);
            end
            checks++;
            if (bt !== 0) begin
                errors++;
                $display("FAIL free_run_tick[%0d]: %0d cycles off the 4-clock grid", i, bt);
            end
        end
    endtask

    task automatic test_sel3();
        int len, bv, bt;
        apply_reset(2'b11);
        measure(2'b00, 8'h01, -1, len, bv, bt);
        checks++;
        if (len !== 192 || bv !== 0) begin
            errors++;
            $display("FAIL sel3_red: len=%0d badval=%0d expected 192/0", len, bv);
        end
        measure(2'b01, 8'h44, -1, len, bv, bt);
        checks++;
        if (len !== 256 || bv !== 0) begin
            errors++;
            $display("FAIL sel3_green: len=%0d badval=%0d expected 256/0", len, bv);
        end
        sel = 2'b00;
    endtask

    task automatic test_hold();
        int len, bv, bt, strobes, badv;
        apply_reset(2'b00);
        measure(2'b00, 8'h01, 0, len, bv, bt);
        step(5);
        hold = 1'b1;
        strobes = 0;
        badv = 0;
        for (int i = 0; i < 39; i++) begin
            step(1);
            if (io_out[5] === 1'b1) strobes++;
            if ((io_out & 8'hDF) !== 8'h44) badv++;
        end
        hold = 1'b0;
        checks++;
        if (strobes !== 10 || badv !== 0) begin
            errors++;
            $display("FAIL hold_window: strobes=%0d badval=%0d expected 10/0", strobes, badv);
        end
        measure(2'b01, 8'h44, 44, len, bv, bt);
        checks++;
        if (len + 44 !== 72 || bt !== 0) begin
            errors++;
            $display("FAIL hold_green_len: got %0d badtick=%0d expected 72/0", len + 44, bt);
        end
        measure(2'b10, 8'h82, 0, len, bv, bt);
        checks++;
        if (len !== 8 || bv !== 0 || bt !== 0) begin
            errors++;
            $display("FAIL hold_yellow_after: len=%0d badval=%0d badtick=%0d expected 8/0/0", len, bv, bt);
        end
    endtask

    // req sampled at edge 4 after release, pulse one clock wide
    task automatic pulse_req_in_red();
        step(3);
        req = 1'b1;
        step(1);
        req = 1'b0;
    endtask

`ifdef SEQ_PED_EN
    task automatic test_ped();
        int len, bv, bt;
        logic [2:0] pend;
        apply_reset(2'b00);
        pulse_req_in_red();
        pend[0] = io_out[4];
        step(1);
        pend[1] = io_out[4];
        step(1);
        pend[2] = io_out[4];
        checks++;
        if (pend !== 3'b100) begin
            errors++;
            $display("FAIL ped_pending_latency: got %b expected 100", pend);
        end
        measure(2'b00, 8'h11, 6, len, bv, bt);
        checks++;
        if (len !== 18 || bv !== 0) begin
            errors++;
            $display("FAIL ped_red_rest: len=%0d badval=%0d expected 18/0", len, bv);
        end
        measure(2'b01, 8'h54, 0, len, bv, bt);
        checks++;
        if (len !== 12 || bv !== 0) begin
            errors++;
            $display("FAIL ped_green_cut: len=%0d badval=%0d expected 12/0", len, bv);
        end
        measure(2'b10, 8'h92, 0, len, bv, bt);
        checks++;
        if (len !== 8 || bv !== 0) begin
            errors++;
            $display("FAIL ped_yellow: len=%0d badval=%0d expected 8/0", len, bv);
        end
        checks++;
        if ((io_out & 8'hDF) !== 8'h09) begin
            errors++;
            $display("FAIL ped_walk_entry: io_out=%h expected 09", io_out);
        end
        measure(2'b00, 8'h09, 0, len, bv, bt);
        checks++;
        if (len !== 24 || bv !== 0) begin
            errors++;
            $display("FAIL ped_walk_red: len=%0d badval=%0d expected 24/0", len, bv);
        end
        checks++;
        if ((io_out & 8'hDF) !== 8'h44) begin
            errors++;
            $display("FAIL ped_walk_clear: io_out=%h expected 44", io_out);
        end
    endtask

    // Request lands after one GREEN tick: 1 elapsed + 1 + GREEN_MIN = 4 ticks
    task automatic test_back_to_back();
        int len, bv, bt;
        step(2);
        req = 1'b1;
        step(1);
        req = 1'b0;
        measure(2'b01, 8'h54, -1, len, bv, bt);
        checks++;
        if (len + 3 !== 16) begin
            errors++;
            $display("FAIL b2b_green_cut: got %0d expected 16", len + 3);
        end
        measure(2'b10, 8'h92, 0, len, bv, bt);
        measure(2'b00, 8'h09, 0, len, bv, bt);
        checks++;
        if (len !== 24 || bv !== 0) begin
            errors++;
            $display("FAIL b2b_walk_red: len=%0d badval=%0d expected 24/0", len, bv);
        end
    endtask
`else
    task automatic test_ped();
        int len, bv, bt;
        apply_reset(2'b00);
        pulse_req_in_red();
        step(2);
        checks++;
        if (io_out[4:3] !== 2'b00) begin
            errors++;
            $display("FAIL noped_pending: io_out[4:3]=%b expected 00", io_out[4:3]);
        end
        measure(2'b00, 8'h01, 6, len, bv, bt);
        checks++;
        if (len !== 18 || bv !== 0) begin
            errors++;
            $display("FAIL noped_red_rest: len=%0d badval=%0d expected 18/0", len, bv);
        end
        measure(2'b01, 8'h44, 0, len, bv, bt);
        checks++;
        if (len !== 32 || bv !== 0) begin
            errors++;
            $display("FAIL noped_green: len=%0d badval=%0d expected 32/0", len, bv);
        end
        measure(2'b10, 8'h82, 0, len, bv, bt);
        measure(2'b00, 8'h01, 0, len, bv, bt);
        checks++;
        if (len !== 24 || bv !== 0) begin
            errors++;
            $display("FAIL noped_red_after: len=%0d badval=%0d expected 24/0", len, bv);
        end
    endtask

    task automatic test_back_to_back();
        int len, bv, bt;
        step(2);
        req = 1'b1;
        step(1);
        req = 1'b0;
        measure(2'b01, 8'h44, -1, len, bv, bt);
        checks++;
        if (len + 3 !== 32 || bv !== 0) begin
            errors++;
            $display("FAIL noped_b2b_green: len=%0d badval=%0d expected 32/0", len + 3, bv);
        end
    endtask
`endif

    initial begin
        #2;
        test_reset();
        test_free_run();
        test_sel3();
        test_hold();
        test_ped();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
